// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use, branch squash, mult/div occupancy, memory wait and halt.
// Optional memory wait timeout is enabled with `define HAZARD_MEM_TIMEOUT_EN.
module hazard_ctrl #(
  parameter int unsigned MULDIV_LAT  = 8,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic [4:0] ex_rt_i,
  input  logic       ex_mem_read_i,
  input  logic       ex_branch_taken_i,
  input  logic       ex_muldiv_i,
  input  logic       mem_req_i,
  input  logic       mem_ack_i,
  input  logic       wb_halt_i,
  output logic [4:0] stall_o,
  output logic [4:0] flush_o,
  output logic       hlt_o,
  output logic       muldiv_done_o,
  output logic       mem_err_o
);

  typedef enum logic [1:0] {RUN, MULDIV, MEMWAIT, HALT} state_e;

  localparam int CW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_LAT - 2);

  state_e        state_q, state_d;
  state_e        ret_q, ret_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        eff;
  logic          mem_wait;
  logic          load_use;
  logic [4:0]    stall_c, flush_c;
  logic          hlt_c, done_c;

`ifdef HAZARD_MEM_TIMEOUT_EN
  logic [7:0] wcnt_q, wcnt_d;
  logic       err_q, err_d;
`endif

  assign load_use = ex_mem_read_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    cnt_d    = cnt_q;
    stall_c  = '0;
    flush_c  = '0;
    hlt_c    = 1'b0;
    done_c   = 1'b0;
    eff      = state_q;
    mem_wait = 1'b0;
`ifdef HAZARD_MEM_TIMEOUT_EN
    wcnt_d   = '0;
    err_d    = err_q;
`endif
    if (state_q == HALT) begin
      hlt_c   = 1'b1;
      stall_c = '1;
    end else begin
      // In MEMWAIT the ack cycle behaves exactly like the preempted state.
      if (state_q == MEMWAIT) begin
        mem_wait = !mem_ack_i;
        eff      = ret_q;
      end else begin
        mem_wait = mem_req_i && !mem_ack_i;
      end

      if (mem_wait) begin
        stall_c[3] = 1'b1;
        state_d    = MEMWAIT;
        if (state_q != MEMWAIT) ret_d = state_q;
`ifdef HAZARD_MEM_TIMEOUT_EN
        if (state_q == MEMWAIT && wcnt_q == 8'(MEM_TIMEOUT)) begin
          stall_c[3] = 1'b0;
          flush_c[3] = 1'b1;
          err_d      = 1'b1;
          state_d    = RUN;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
`endif
      end else begin
        state_d = eff;
        if (eff == MULDIV) begin
          if (cnt_q != '0) begin
            stall_c[2] = 1'b1;
            cnt_d      = cnt_q - 1'b1;
          end else begin
            done_c  = 1'b1;
            state_d = RUN;
          end
        end else if (ex_muldiv_i) begin
          stall_c[2] = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = MULDIV;
        end

        if (!stall_c[2]) begin
          if (ex_branch_taken_i) flush_c[1] = 1'b1;
          else if (load_use)     stall_c[1] = 1'b1;
        end
      end

      if (wb_halt_i) state_d = HALT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end
  assign mem_err_o = err_q;
`else
  assign mem_err_o = 1'b0;
`endif

  assign stall_o       = rst ? stall_c : 5'b0;
  assign flush_o       = rst ? flush_c : 5'b0;
  assign hlt_o         = rst & hlt_c;
  assign muldiv_done_o = rst & done_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table plus multi-cycle sequences.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken, ex_muldiv;
  logic       mem_req, mem_ack, wb_halt;
  logic [4:0] stall, flush;
  logic       hlt, muldiv_done, mem_err;
  int         n_cmp = 0;
  int         n_bad = 0;

  hazard_ctrl #(.MULDIV_LAT(8), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt), .ex_rt_i(ex_rt),
    .ex_mem_read_i(ex_mem_read), .ex_branch_taken_i(ex_branch_taken),
    .ex_muldiv_i(ex_muldiv), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
    .wb_halt_i(wb_halt),
    .stall_o(stall), .flush_o(flush), .hlt_o(hlt),
    .muldiv_done_o(muldiv_done), .mem_err_o(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urt;
    logic [4:0] ert;
    logic       ld, br;
    logic [4:0] st, fl;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [4:0] st, input logic [4:0] fl,
                         input logic hl, input logic dn);
    chk({nm, ".stall"}, 32'(stall), 32'(st));
    chk({nm, ".flush"}, 32'(flush), 32'(fl));
    chk({nm, ".hlt"}, 32'(hlt), 32'(hl));
    chk({nm, ".done"}, 32'(muldiv_done), 32'(dn));
  endtask

  task automatic clr();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rt = 0; ex_mem_read = 0;
    ex_branch_taken = 0; ex_muldiv = 0; mem_req = 0; mem_ack = 0; wb_halt = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{rs:5, rt:0, urt:0, ert:5, ld:1, br:0, st:5'b00010, fl:5'b00000};
    vt[1] = '{rs:0, rt:0, urt:0, ert:0, ld:1, br:0, st:5'b00000, fl:5'b00000};
    vt[2] = '{rs:3, rt:7, urt:1, ert:7, ld:1, br:0, st:5'b00010, fl:5'b00000};
    vt[3] = '{rs:3, rt:7, urt:0, ert:7, ld:1, br:0, st:5'b00000, fl:5'b00000};
    vt[4] = '{rs:5, rt:0, urt:0, ert:5, ld:0, br:0, st:5'b00000, fl:5'b00000};
    vt[5] = '{rs:5, rt:0, urt:0, ert:5, ld:1, br:1, st:5'b00000, fl:5'b00010};
    vt[6] = '{rs:1, rt:2, urt:1, ert:9, ld:0, br:1, st:5'b00000, fl:5'b00010};
    vt[7] = '{rs:6, rt:9, urt:1, ert:5, ld:1, br:0, st:5'b00000, fl:5'b00000};

    // Reset: outputs forced low even with a live load-use match.
    clr();
    rst = 1'b0;
    id_rs = 5; ex_rt = 5; ex_mem_read = 1;
    #2;
    chk_all("reset", 5'b0, 5'b0, 1'b0, 1'b0);
    chk("reset.mem_err", 32'(mem_err), 32'd0);
    cyc(); cyc();
    clr();
    rst = 1'b1;
    #2;
    chk_all("post_reset", 5'b0, 5'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      cyc();
      clr();
      id_rs = vt[i].rs; id_rt = vt[i].rt; id_uses_rt = vt[i].urt; ex_rt = vt[i].ert;
      ex_mem_read = vt[i].ld; ex_branch_taken = vt[i].br;
      #2;
      chk_all($sformatf("vec%0d", i), vt[i].st, vt[i].fl, 1'b0, 1'b0);
    end

    // Mult/div with a taken branch held: flush only on the release cycle.
    cyc(); clr();
    ex_muldiv = 1; ex_branch_taken = 1;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (c < 7) chk_all($sformatf("md%0d", c), 5'b00100, 5'b0, 1'b0, 1'b0);
      else       chk_all($sformatf("md%0d", c), 5'b00000, 5'b00010, 1'b0, 1'b1);
      cyc();
    end
    clr();
    #2;
    chk_all("md_after", 5'b0, 5'b0, 1'b0, 1'b0);

    // Memory wait preempting a mult/div; count resumes from its frozen value.
    cyc(); clr();
    ex_muldiv = 1;
    for (int c = 0; c < 11; c++) begin
      mem_req = (c >= 3 && c <= 6);
      mem_ack = (c == 6);
      #2;
      if (c >= 3 && c <= 5) chk_all($sformatf("mw%0d", c), 5'b01000, 5'b0, 1'b0, 1'b0);
      else if (c == 10)     chk_all($sformatf("mw%0d", c), 5'b00000, 5'b0, 1'b0, 1'b1);
      else                  chk_all($sformatf("mw%0d", c), 5'b00100, 5'b0, 1'b0, 1'b0);
      cyc();
    end
    clr();

    // Taken branch during a memory wait: flush appears on the ack cycle.
    ex_branch_taken = 1; id_rs = 5; ex_rt = 5; ex_mem_read = 1;
    for (int c = 0; c < 4; c++) begin
      mem_req = 1;
      mem_ack = (c == 3);
      #2;
      if (c < 3) chk_all($sformatf("bw%0d", c), 5'b01000, 5'b0, 1'b0, 1'b0);
      else       chk_all($sformatf("bw%0d", c), 5'b00000, 5'b00010, 1'b0, 1'b0);
      cyc();
    end
    clr();

    // mem_req and ex_muldiv together: memory first, then full mult/div.
    ex_muldiv = 1;
    for (int c = 0; c < 10; c++) begin
      mem_req = (c <= 2);
      mem_ack = (c == 2);
      #2;
      if (c < 2)       chk_all($sformatf("mm%0d", c), 5'b01000, 5'b0, 1'b0, 1'b0);
      else if (c == 9) chk_all($sformatf("mm%0d", c), 5'b00000, 5'b0, 1'b0, 1'b1);
      else             chk_all($sformatf("mm%0d", c), 5'b00100, 5'b0, 1'b0, 1'b0);
      cyc();
    end
    clr();

    // Reset in the middle of a mult/div clears the counter and state.
    ex_muldiv = 1;
    cyc(); cyc();
    #2;
    chk_all("rmd_busy", 5'b00100, 5'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk_all("rmd_rst", 5'b0, 5'b0, 1'b0, 1'b0);
    cyc();
    clr();
    rst = 1'b1;
    #2;
    chk_all("rmd_rel", 5'b0, 5'b0, 1'b0, 1'b0);
    cyc();

`ifdef HAZARD_MEM_TIMEOUT_EN
    mem_req = 1;
    for (int c = 0; c < 5; c++) begin
      #2;
      if (c < 4) chk_all($sformatf("to%0d", c), 5'b01000, 5'b0, 1'b0, 1'b0);
      else       chk_all($sformatf("to%0d", c), 5'b00000, 5'b01000, 1'b0, 1'b0);
      chk($sformatf("to%0d.err", c), 32'(mem_err), 32'd0);
      cyc();
    end
    clr();
    #2;
    chk("to_err_set", 32'(mem_err), 32'd1);
    chk_all("to_after", 5'b0, 5'b0, 1'b0, 1'b0);
    cyc();
`else
    mem_req = 1;
    for (int c = 0; c < 7; c++) begin
      mem_ack = (c == 6);
      #2;
      chk($sformatf("nto%0d.stall", c), 32'(stall), (c < 6) ? 32'h08 : 32'h00);
      chk($sformatf("nto%0d.err", c), 32'(mem_err), 32'd0);
      cyc();
    end
    clr();
`endif

    // Halt: effective next cycle, ignores all inputs, left only by reset.
    wb_halt = 1; id_rs = 5; ex_rt = 5; ex_mem_read = 1;
    #2;
    chk_all("h_req", 5'b00010, 5'b0, 1'b0, 1'b0);
    cyc();
    clr();
    ex_branch_taken = 1; mem_req = 1; ex_muldiv = 1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk_all($sformatf("halt%0d", c), 5'b11111, 5'b0, 1'b1, 1'b0);
      cyc();
    end
    rst = 1'b0;
    #1;
    chk_all("h_rst", 5'b0, 5'b0, 1'b0, 1'b0);
    chk("h_rst.mem_err", 32'(mem_err), 32'd0);
    cyc();
    clr();
    rst = 1'b1;
    #2;
    chk_all("h_rel", 5'b0, 5'b0, 1'b0, 1'b0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
